// File: rtl/inst_encoder_pkg.sv
// -----------------------------------------------------------------------------
// inst_encoder_pkg
// Shared constants for the instruction encoder: mnemonic codes, MIPS opcode and
// funct values, and the encoder FSM state type.
// No ports (package). Imported by inst_field_pack and inst_encoder.
// -----------------------------------------------------------------------------
package inst_encoder_pkg;

    // Mnemonic codes as presented on the mnem input (14 and 15 are illegal)
    localparam logic [3:0] MN_ADD   = 4'd0;
    localparam logic [3:0] MN_SUB   = 4'd1;
    localparam logic [3:0] MN_AND   = 4'd2;
    localparam logic [3:0] MN_OR    = 4'd3;
    localparam logic [3:0] MN_XOR   = 4'd4;
    localparam logic [3:0] MN_NOR   = 4'd5;
    localparam logic [3:0] MN_SLTU  = 4'd6;
    localparam logic [3:0] MN_SLLV  = 4'd7;
    localparam logic [3:0] MN_ADDI  = 4'd8;
    localparam logic [3:0] MN_ANDI  = 4'd9;
    localparam logic [3:0] MN_XORI  = 4'd10;
    localparam logic [3:0] MN_SLTIU = 4'd11;
    localparam logic [3:0] MN_LW    = 4'd12;
    localparam logic [3:0] MN_SW    = 4'd13;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;

    // Opcode values (R-type shares opcode zero)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/inst_field_pack.sv
// -----------------------------------------------------------------------------
// inst_field_pack
// Purely combinational packing of a mnemonic plus register/immediate fields
// into a 32-bit MIPS instruction word.
// Ports:
//   mnem    in  4   mnemonic code
//   rs/rt/rd in 5   register fields (rd ignored for I-type)
//   imm     in  16  immediate/offset (ignored for R-type)
//   word    out 32  packed instruction (zero when illegal)
//   illegal out 1   mnemonic 14/15
// -----------------------------------------------------------------------------
module inst_field_pack
    import inst_encoder_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [5:0] funct;
    logic [5:0] op;
    logic       is_rtype;

    always_comb begin
        funct    = 6'b000000;
        op       = OP_RTYPE;
        is_rtype = 1'b0;
        illegal  = 1'b0;
        case (mnem)
            MN_ADD:   begin is_rtype = 1'b1; funct = FUNCT_ADD;  end
            MN_SUB:   begin is_rtype = 1'b1; funct = FUNCT_SUB;  end
            MN_AND:   begin is_rtype = 1'b1; funct = FUNCT_AND;  end
            MN_OR:    begin is_rtype = 1'b1; funct = FUNCT_OR;   end
            MN_XOR:   begin is_rtype = 1'b1; funct = FUNCT_XOR;  end
            MN_NOR:   begin is_rtype = 1'b1; funct = FUNCT_NOR;  end
            MN_SLTU:  begin is_rtype = 1'b1; funct = FUNCT_SLTU; end
            MN_SLLV:  begin is_rtype = 1'b1; funct = FUNCT_SLLV; end
            MN_ADDI:  op = OP_ADDI;
            MN_ANDI:  op = OP_ANDI;
            MN_XORI:  op = OP_XORI;
            MN_SLTIU: op = OP_SLTIU;
            MN_LW:    op = OP_LW;
            MN_SW:    op = OP_SW;
            default:  illegal = 1'b1;
        endcase

        if (illegal) begin
            word = 32'h0000_0000;
        end else if (is_rtype) begin
            word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
        end else begin
            word = {op, rs, rt, imm};
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Accepts instruction requests, encodes them to MIPS words and writes them
// sequentially into an instruction memory of 2**ADDR_W words.
// Optional feature: define INST_ENCODER_CHECKSUM_EN to add a running XOR
// checksum of all written words on output 'checksum'.
// Ports:
//   clk, rst (sync, active high), clear (sync restart of load sequence)
//   in_valid/in_ready  request handshake; mnem/rs/rt/rd/imm request fields
//   mem_we/mem_addr/mem_wdata  instruction-memory write port
//   count (ADDR_W+1)  words written; full  memory full; err  sticky illegal flag
//   checksum (32, optional)  XOR of all written words since reset/clear
// -----------------------------------------------------------------------------
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
`ifdef INST_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    // count value at which the memory is full (MSB set, rest zero)
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         packed_word;
    logic                packed_illegal;
    logic [ADDR_W:0]     count_inc;

    inst_field_pack u_pack (
        .mnem    (mnem),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .imm     (imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        word_d  = word_q;
        addr_d  = addr_q;
        if (clear) begin
            // clear wins over any handshake; word/addr keep their last values
            state_d = ST_IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (packed_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            word_d  = packed_word;
                            addr_d  = count_q[ADDR_W-1:0];
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    count_d = count_inc;
                    state_d = (count_inc == DEPTH) ? ST_FULL : ST_IDLE;
                end
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

    // The strobe is combinational so that rst or clear in the WRITE cycle
    // can abort the write in that same cycle.
    assign mem_we    = (state_q == ST_WRITE) && !clear && !rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign full      = (state_q == ST_FULL);
    assign count     = count_q;
    assign err       = err_q;

`ifdef INST_ENCODER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (clear) begin
            checksum_d = '0;
        end else if (mem_we) begin
            checksum_d = checksum_q ^ word_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Scoreboard bench for inst_encoder: the stimulus thread pushes expected
// writes into a queue, a negedge monitor pops and compares every mem_we.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        mnem = '0;
    logic [4:0]        rs = '0, rt = '0, rd = '0;
    logic [15:0]       imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
`ifdef INST_ENCODER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    inst_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mnem      (mnem),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err)
`ifdef INST_ENCODER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          m_count = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_csum = '0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding straight from the instruction-format tables
    function automatic logic [31:0] ref_word(input int m, input int r_s, input int r_t,
                                             input int r_d, input int im);
        int funct_tab[8] = '{32, 34, 36, 37, 38, 39, 43, 4};
        int op_tab[6]    = '{8, 12, 14, 11, 35, 43};
        logic [31:0] w;
        if (m < 8) w = 32'(r_s << 21) | 32'(r_t << 16) | 32'(r_d << 11) | 32'(funct_tab[m]);
        else       w = (32'(op_tab[m-8]) << 26) | 32'(r_s << 21) | 32'(r_t << 16) | 32'(im);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; exp_word overrides the model when use_lit is set
    task automatic issue(input int mn, input int a, input int b, input int c, input int im,
                         input logic [31:0] exp_word, input bit use_lit);
        int waited = 0;
        bit legal;
        logic [31:0] w;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            chk("ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        mnem = 4'(mn); rs = 5'(a); rt = 5'(b); rd = 5'(c); imm = 16'(im);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        legal = (mn <= 13);
        w = use_lit ? exp_word : ref_word(mn, a, b, c, im);
        if (legal) begin
            exp_q.push_back('{addr: ADDR_W'(m_count), data: w});
            m_csum ^= w;
            m_count++;
        end else begin
            m_err = 1'b1;
        end
        // one-cycle latency: strobe present right after the handshake, only if legal
        chk("latency_we", {63'd0, mem_we}, {63'd0, legal});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_count = 0;
        m_err = 1'b0;
        m_csum = '0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(m_count));
        chk({tag, "_err"}, {63'd0, err}, {63'd0, m_err});
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (mon_en && mem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0d data=0x%08h expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=0x%08h (exp addr=%0d data=0x%08h)", mem_addr, mem_wdata, e.addr, e.data);
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mn;
        // ---------------- reset state ----------------
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        mon_en = 1'b1;

        // ---------------- directed encodings ----------------
        issue(0, 1, 2, 3, 16'h1234, 32'h0022_1820, 1'b1);
        tick();
        chk_status("add");
        issue(12, 1, 5, 0, 4, 32'h8C25_0004, 1'b1);
        issue(13, 2, 5, 0, 8, 32'hAC45_0008, 1'b1);
        tick();
        chk_status("lwsw");
        issue(8, 0, 1, 31, 16'hFFFF, 32'h2001_FFFF, 1'b1);
        tick();
        issue(14, 3, 3, 3, 16'h00FF, 32'h0, 1'b1);
        tick();
        chk_status("illegal");
        chk("illegal_ready", {63'd0, in_ready}, 64'd1);
        issue(4, 7, 8, 9, 0, 32'h0, 1'b0);
        tick();
        chk_status("after_illegal");

        // ---------------- randomized mix ----------------
        do_clear();
        chk_status("clear1");
        for (int i = 0; i < 40; i++) begin
            mn = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13);
            issue(mn, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 16'hFFFF), 32'h0, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        chk_status("rand");
`ifdef INST_ENCODER_CHECKSUM_EN
        chk("rand_csum", 64'(checksum), 64'(m_csum));
`endif

        // ---------------- fill to full, back to back ----------------
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            issue($urandom_range(0, 13), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 16'hFFFF), 32'h0, 1'b0);
        end
        tick();
        chk("full_flag", {63'd0, full}, 64'd1);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        mnem = 4'd0; in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("full_hold_count", 64'(count), 64'(DEPTH));
        chk("full_hold_flag", {63'd0, full}, 64'd1);
        do_clear();
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_ready", {63'd0, in_ready}, 64'd1);
        chk("clr_full", {63'd0, full}, 64'd0);

        // ---------------- rst during WRITE ----------------
        issue(1, 4, 5, 6, 0, 32'h0, 1'b0);
        tick();
        mnem = 4'd2; rs = 5'd9; rt = 5'd9; rd = 5'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_write_we", {63'd0, mem_we}, 64'd0);
        tick();
        rst = 1'b0;
        m_count = 0; m_err = 1'b0; m_csum = '0;
        chk("rstw_count", 64'(count), 64'd0);
        chk("rstw_ready", {63'd0, in_ready}, 64'd1);
        chk("rstw_wdata", 64'(mem_wdata), 64'd0);

`ifdef INST_ENCODER_CHECKSUM_EN
        // ---------------- checksum ----------------
        chk("csum_reset", 64'(checksum), 64'd0);
        issue(0, 1, 2, 3, 0, 32'h0022_1820, 1'b1);
        issue(8, 0, 1, 0, 16'hFFFF, 32'h2001_FFFF, 1'b1);
        tick();
        chk("csum_value", 64'(checksum), 64'h2023_E7DF);
        do_clear();
        chk("csum_clear", 64'(checksum), 64'd0);
`endif

        repeat (3) tick();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
